// File: rtl/hram_arb_pkg.sv
// Shared types and constants for the HRAM arbiter and its address checker.
package hram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam logic [7:0] HRAM_LO = 8'h80;
  localparam logic [7:0] IE_ADDR = 8'hFF;

  // One requester's access fields, bundled for muxing.
  typedef struct packed {
    logic       we;
    logic [7:0] a;
    logic [7:0] wdata;
  } hram_req_t;

endpackage

// File: rtl/hram_range_chk.sv
// Combinational HRAM window check: FF80..FFFE is HRAM, FFFF (IE) is not.
module hram_range_chk
  import hram_arb_pkg::*;
(
  input  logic [7:0] a,
  output logic       in_range
);

  assign in_range = (a >= HRAM_LO) && (a != IE_ADDR);

endmodule

// File: rtl/hram_arbiter.sv
// Two-port (CPU / DMA) arbiter and two-cycle access sequencer for high RAM.
// Optional DMA starvation guard: define HRAM_ARB_STARVE_EN.
module hram_arbiter
  import hram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter logic [7:0]  OOR_RDATA    = 8'hFF
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_a,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_a,
  input  logic [7:0] dma_wdata,
  output logic       dma_ack,
  output logic [7:0] dma_rdata,
  output logic [7:0] hram_a,
  output logic       hram_ffxx,
  output logic       hram_rd,
  output logic       hram_wr,
  output logic [7:0] hram_dout,
  output logic       hram_doe,
  input  logic [7:0] hram_din,
  output logic       busy
);

  state_e    state, state_nxt;
  owner_e    owner, win;
  hram_req_t cpu_rq, dma_rq, win_rq;
  logic      any_req, grant, dma_wins, win_inr;
  logic      we_q, inr_q;
  logic [7:0] hram_a_d, hram_dout_d;
  logic      ffxx_d, rd_d, wr_d, doe_d;
  logic      starve_hit;

  assign cpu_rq  = '{we: cpu_we, a: cpu_a, wdata: cpu_wdata};
  assign dma_rq  = '{we: dma_we, a: dma_a, wdata: dma_wdata};
  assign any_req = cpu_req | dma_req;
  // Arbitration happens whenever no macro strobe is in flight (IDLE or DONE).
  assign grant   = any_req && (state != ACCESS);

`ifdef HRAM_ARB_STARVE_EN
  logic [1:0] starve_cnt;

  assign starve_hit = (32'(starve_cnt) == STARVE_LIMIT);

  // Count consecutive DMA losses; any DMA win clears the count.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      starve_cnt <= '0;
    end else if (grant && dma_req) begin
      if (dma_wins)                starve_cnt <= '0;
      else if (starve_cnt != 2'd3) starve_cnt <= starve_cnt + 2'd1;
    end
  end
`else
  logic unused_starve_limit;

  assign starve_hit          = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  // CPU wins ties unless the DMA port has been starved too long.
  assign dma_wins = dma_req && (!cpu_req || starve_hit);
  assign win      = dma_wins ? OWN_DMA : OWN_CPU;
  assign win_rq   = dma_wins ? dma_rq : cpu_rq;

  hram_range_chk u_range (
    .a        (win_rq.a),
    .in_range (win_inr)
  );

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: every slot is ACCESS then DONE; DONE chains straight into a new slot.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = any_req ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Macro-facing next values: strobes are set only for the cycle after a grant.
  always_comb begin
    hram_a_d    = hram_a;
    hram_dout_d = hram_dout;
    ffxx_d      = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    doe_d       = 1'b0;
    if (grant) begin
      hram_a_d    = win_rq.a;
      hram_dout_d = win_rq.wdata;
      if (win_inr) begin
        ffxx_d = 1'b1;
        rd_d   = !win_rq.we;
        wr_d   = win_rq.we;
        doe_d  = win_rq.we;
      end
    end
  end

  // Datapath: hram_a / hram_dout double as the latched address and write data.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      owner     <= OWN_CPU;
      we_q      <= 1'b0;
      inr_q     <= 1'b0;
      hram_a    <= '0;
      hram_dout <= '0;
      hram_ffxx <= 1'b0;
      hram_rd   <= 1'b0;
      hram_wr   <= 1'b0;
      hram_doe  <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      hram_a    <= hram_a_d;
      hram_dout <= hram_dout_d;
      hram_ffxx <= ffxx_d;
      hram_rd   <= rd_d;
      hram_wr   <= wr_d;
      hram_doe  <= doe_d;
      if (grant) begin
        owner <= win;
        we_q  <= win_rq.we;
        inr_q <= win_inr;
      end
      if (state == ACCESS && !we_q) begin
        if (owner == OWN_CPU) cpu_rdata <= inr_q ? hram_din : OOR_RDATA;
        else                  dma_rdata <= inr_q ? hram_din : OOR_RDATA;
      end
    end
  end

  assign cpu_ack = (state == DONE) && (owner == OWN_CPU);
  assign dma_ack = (state == DONE) && (owner == OWN_DMA);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_hram_arbiter.sv
// Bench for hram_arbiter: directed scenarios plus random two-port traffic
// against a slot-level reference model and a behavioural HRAM macro.
module tb_hram_arbiter;

  localparam int LIMIT = 3;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_a = '0, cpu_wdata = '0;
  logic       dma_req = 1'b0, dma_we = 1'b0;
  logic [7:0] dma_a = '0, dma_wdata = '0;
  logic       cpu_ack, dma_ack;
  logic [7:0] cpu_rdata, dma_rdata;
  logic [7:0] hram_a, hram_dout, hram_din;
  logic       hram_ffxx, hram_rd, hram_wr, hram_doe, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hram_arbiter #(.STARVE_LIMIT(LIMIT), .OOR_RDATA(8'hFF)) dut (
    .clk(clk), .n_reset(n_reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_a(dma_a), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .hram_a(hram_a), .hram_ffxx(hram_ffxx), .hram_rd(hram_rd), .hram_wr(hram_wr),
    .hram_dout(hram_dout), .hram_doe(hram_doe), .hram_din(hram_din), .busy(busy)
  );

  // ---------------- HRAM macro model ----------------
  logic [7:0] mem [256];
  assign hram_din = mem[hram_a];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    forever begin
      @(negedge clk);
      if (n_reset && hram_wr && hram_ffxx && hram_doe) mem[hram_a] = hram_dout;
    end
  end

  // ---------------- check helpers ----------------
  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slot-level reference model ----------------
  // slot_left: 2 = strobe cycle of current slot, 1 = acknowledge cycle, 0 = no slot.
  int         slot_left;
  logic       m_own_dma, m_we, m_inr;
  logic [7:0] m_a, m_wd;
  logic [7:0] ref_mem [256];
  logic [7:0] exp_cpu_rd, exp_dma_rd;
  int         losses;

  function automatic logic in_hram(input logic [7:0] a);
    return (a >= 8'h80) && (a != 8'hFF);
  endfunction

  task automatic model_reset();
    slot_left  = 0;
    exp_cpu_rd = 8'h00;
    exp_dma_rd = 8'h00;
    losses     = 0;
    m_own_dma  = 1'b0;
    m_we       = 1'b0;
    m_inr      = 1'b0;
    m_a        = 8'h00;
    m_wd       = 8'h00;
  endtask

  task automatic model_step();
    logic starve, dma_first;
    logic [7:0] rd;
    starve = 1'b0;
    if (!n_reset) begin
      model_reset();
      return;
    end
    if (slot_left == 2) begin
      // end of the strobe cycle: the access takes effect
      if (m_we) begin
        if (m_inr) ref_mem[m_a] = m_wd;
      end else begin
        rd = m_inr ? ref_mem[m_a] : 8'hFF;
        if (m_own_dma) exp_dma_rd = rd;
        else           exp_cpu_rd = rd;
      end
      slot_left = 1;
    end else begin
      slot_left = 0;
      if (cpu_req || dma_req) begin
`ifdef HRAM_ARB_STARVE_EN
        starve = (losses == LIMIT);
`endif
        dma_first = dma_req && (!cpu_req || starve);
        if (dma_req) losses = dma_first ? 0 : ((losses < 3) ? losses + 1 : losses);
        m_own_dma = dma_first;
        m_we      = dma_first ? dma_we    : cpu_we;
        m_a       = dma_first ? dma_a     : cpu_a;
        m_wd      = dma_first ? dma_wdata : cpu_wdata;
        m_inr     = in_hram(m_a);
        slot_left = 2;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check1("busy", busy, slot_left != 0);
    check1("cpu_ack", cpu_ack, (slot_left == 1) && !m_own_dma);
    check1("dma_ack", dma_ack, (slot_left == 1) && m_own_dma);
    check8("cpu_rdata", cpu_rdata, exp_cpu_rd);
    check8("dma_rdata", dma_rdata, exp_dma_rd);
    if (slot_left == 2) begin
      check8("hram_a", hram_a, m_a);
      check1("hram_ffxx", hram_ffxx, m_inr);
      check1("hram_rd", hram_rd, m_inr && !m_we);
      check1("hram_wr", hram_wr, m_inr && m_we);
      check1("hram_doe", hram_doe, m_inr && m_we);
      if (m_inr && m_we) check8("hram_dout", hram_dout, m_wd);
    end else begin
      check1("hram_ffxx_idle", hram_ffxx, 1'b0);
      check1("hram_rd_idle", hram_rd, 1'b0);
      check1("hram_wr_idle", hram_wr, 1'b0);
      check1("hram_doe_idle", hram_doe, 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cpu_xfer(input logic we, input logic [7:0] a, input logic [7:0] wd,
                          output int lat, output int wrc, output int stc);
    cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_wdata = wd;
    lat = 0; wrc = 0; stc = 0;
    do begin
      tick();
      lat++;
      if (hram_wr) wrc++;
      if (hram_ffxx || hram_rd) stc++;
    end while (!cpu_ack && lat < 10);
    cpu_req = 1'b0;
  endtask

  function automatic logic [7:0] pick_addr();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 8'hFF;
    if (r == 1) return 8'($urandom_range(0, 127));
    return 8'($urandom_range(128, 143));
  endfunction

  task automatic rand_port(inout logic req, input logic ack, inout logic we,
                           inout logic [7:0] a, inout logic [7:0] wd);
    if (req && ack) begin
      if ($urandom_range(0, 3) == 0) begin
        we = 1'($urandom_range(0, 1)); a = pick_addr(); wd = 8'($urandom);
      end else begin
        req = 1'b0;
      end
    end else if (!req && $urandom_range(0, 9) < 4) begin
      req = 1'b1; we = 1'($urandom_range(0, 1)); a = pick_addr(); wd = 8'($urandom);
    end
  endtask

  initial begin
    int lat, wrc, stc, c_at, d_at, n_c, n_d;
    logic [7:0] seq [$];

    // reset state
    repeat (3) @(posedge clk);
    #2;
    check1("rst_busy", busy, 1'b0);
    check1("rst_cpu_ack", cpu_ack, 1'b0);
    check1("rst_dma_ack", dma_ack, 1'b0);
    check1("rst_hram_wr", hram_wr, 1'b0);
    check8("rst_hram_a", hram_a, 8'h00);
    check8("rst_hram_dout", hram_dout, 8'h00);
    check8("rst_cpu_rdata", cpu_rdata, 8'h00);
    check8("rst_dma_rdata", dma_rdata, 8'h00);
    n_reset = 1'b1;
    tick();

    // write FF80 <- 5A, then read it back
    cpu_xfer(1'b1, 8'h80, 8'h5A, lat, wrc, stc);
    checki("wr_latency", lat, 2);
    checki("wr_strobe_cycles", wrc, 1);
    cpu_xfer(1'b0, 8'h80, 8'h00, lat, wrc, stc);
    checki("rd_latency", lat, 2);
    check8("rd_data", cpu_rdata, 8'h5A);
    checki("rd_no_write", wrc, 0);

    // simultaneous reads: CPU first, DMA one slot later
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 8'h90;
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 8'hA0;
    c_at = 0; d_at = 0;
    seq.delete();
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (hram_rd) seq.push_back(hram_a);
      if (cpu_ack) begin c_at = k; cpu_req = 1'b0; end
      if (dma_ack) begin d_at = k; dma_req = 1'b0; end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    checki("tie_cpu_ack_cycle", c_at, 2);
    checki("tie_dma_ack_cycle", d_at, 4);
    checki("tie_strobe_count", seq.size(), 2);
    check8("tie_addr0", (seq.size() > 0) ? seq[0] : 8'h00, 8'h90);
    check8("tie_addr1", (seq.size() > 1) ? seq[1] : 8'h00, 8'hA0);

    // out-of-range reads
    cpu_xfer(1'b0, 8'h7F, 8'h00, lat, wrc, stc);
    checki("oor7f_latency", lat, 2);
    check8("oor7f_rdata", cpu_rdata, 8'hFF);
    checki("oor7f_strobes", stc, 0);
    cpu_xfer(1'b0, 8'h81, 8'h00, lat, wrc, stc);
    check8("ff81_rdata", cpu_rdata, 8'hB0);
    cpu_xfer(1'b0, 8'hFF, 8'h00, lat, wrc, stc);
    checki("ie_latency", lat, 2);
    check8("ie_rdata", cpu_rdata, 8'hFF);
    checki("ie_strobes", stc, 0);

    // continuous contention for 16 slots
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 8'h81;
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 8'h82;
    n_c = 0; n_d = 0;
    repeat (32) begin
      tick();
      if (cpu_ack) n_c++;
      if (dma_ack) n_d++;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
`ifdef HRAM_ARB_STARVE_EN
    checki("starve_dma_acks", n_d, 4);
    checki("starve_cpu_acks", n_c, 12);
`else
    checki("fixed_dma_acks", n_d, 0);
    checki("fixed_cpu_acks", n_c, 16);
`endif

    // reset during the strobe cycle of a write
    tick();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 8'h85; cpu_wdata = 8'h33;
    tick();
    check1("abort_pre_wr", hram_wr, 1'b1);
    #1;
    n_reset = 1'b0;
    model_reset();
    #1;
    check1("abort_wr", hram_wr, 1'b0);
    check1("abort_ffxx", hram_ffxx, 1'b0);
    check1("abort_doe", hram_doe, 1'b0);
    check1("abort_busy", busy, 1'b0);
    cpu_req = 1'b0;
    tick();
    check1("abort_no_ack", cpu_ack, 1'b0);
    n_reset = 1'b1;
    cpu_xfer(1'b0, 8'h85, 8'h00, lat, wrc, stc);
    checki("post_reset_latency", lat, 2);

    // random two-port traffic
    for (int t = 0; t < 3000; t++) begin
      tick();
      rand_port(cpu_req, cpu_ack, cpu_we, cpu_a, cpu_wdata);
      rand_port(dma_req, dma_ack, dma_we, dma_a, dma_wdata);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hram_arbiter.md
# hram_arbiter

Two-port arbiter and access sequencer for the 127-byte high RAM (FF80–FFFE).
- It shares the HRAM macro between the CPU bus port and a secondary DMA/debug port, and serialises their accesses into fixed two-cycle slots.
- It drives the macro's address, read/write strobes, page-select and write data, and returns read data with a one-cycle acknowledge.
- It sits between the SoC bus decoder and the HRAM macro.

## Interface
Parameters:
- STARVE_LIMIT, 3: consecutive DMA losses before DMA is forced to win (only with starvation guard compiled in).
- OOR_RDATA, 8'hFF: read data returned for addresses outside FF80–FFFE.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with cpu_we/cpu_a/cpu_wdata until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_a  in  8  low address byte within page FFxx.
- cpu_wdata  in  8  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data, valid in the cycle cpu_ack is high; otherwise holds its last value.
- dma_req, dma_we, dma_a[7:0], dma_wdata[7:0], dma_ack, dma_rdata[7:0]: same semantics, for the DMA/debug port.
- hram_a  out  8  address to the macro.
- hram_ffxx  out  1  page select, high only during an in-range access slot.
- hram_rd  out  1  read strobe to the macro.
- hram_wr  out  1  write strobe to the macro.
- hram_dout  out  8  write data to the macro.
- hram_doe  out  1  enables the hram_dout drive onto the macro's bidirectional data bus.
- hram_din  in  8  read data from the macro.
- busy  out  1  high while a slot is in progress (state ≠ IDLE).

## Operation
- States:
  - IDLE: no slot in progress.
  - ACCESS: the macro is strobed.
  - DONE: the requester is acknowledged.
- Arbitration happens in IDLE and in DONE, on every edge where cpu_req or dma_req is high. Default priority is fixed: CPU wins ties.
- The winner's request fields are latched into internal registers (owner, we, a, wdata) on entry to ACCESS. Requester inputs are not sampled again in that slot.
- ACCESS (1 cycle):
  - hram_a = latched address.
  - In range (a ≥ 8'h80 and a ≠ 8'hFF): hram_ffxx = 1; hram_rd = !we; hram_wr = we; hram_doe = we; hram_dout = wdata.
  - Out of range: all strobes stay 0.
- DONE (1 cycle):
  - The owner's ack = 1.
  - For a read, the owner's rdata = hram_din captured at the end of ACCESS, or OOR_RDATA when out of range.
  - Writes leave rdata unchanged.
- Transitions:
  - IDLE → ACCESS when any request is pending.
  - ACCESS → DONE always.
  - DONE → ACCESS if a request is pending, otherwise DONE → IDLE.
- A requester still holding req in its own DONE cycle is treated as a new request. It re-arbitrates in that same cycle, so requesters must drop req in the ack cycle unless they want back-to-back accesses.
- Simultaneous requests: one winner per slot. The loser's request stays pending and is served in the next slot.
- Out-of-range accesses consume a full slot and are acknowledged normally; 8'hFF (IE) is never strobed.

## Timing
- Reset values:
  - State: IDLE.
  - All acks, hram_rd, hram_wr, hram_ffxx, hram_doe, busy: 0.
  - hram_a, hram_dout, cpu_rdata, dma_rdata: 8'h00.
  - Starvation counter: 0.
- Latency is 2 cycles from the edge sampling req to the ack-high cycle. Sustained throughput is 1 access per 2 cycles.
- All macro-facing outputs are registered; no combinational path from req to hram_*.
- Reset asserted mid-slot aborts the slot immediately:
  - Strobes drop asynchronously.
  - No ack is issued.
  - A write in progress may or may not have landed.

## Configuration
- HRAM_ARB_STARVE_EN defined:
  - A 2-bit counter increments each time DMA requests and loses, and clears when DMA wins.
  - When the count equals STARVE_LIMIT, DMA wins the next arbitration regardless of cpu_req.
- Undefined: pure fixed CPU priority. The counter and the STARVE_LIMIT logic are absent, and the DMA port can starve.

## Structure
- Package hram_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - the owner enum (OWN_CPU, OWN_DMA);
  - the constants HRAM_LO = 8'h80 and IE_ADDR = 8'hFF.
- One sub-module, hram_range_chk: combinational, 8-bit address in, in_range out. It is also reused by the bus decoder.

## Test plan
- CPU write 8'h80 ← 8'h5A, then read 8'h80 → cpu_ack 2 cycles after each req; read returns 8'h5A; hram_wr high exactly 1 cycle.
- Simultaneous cpu_req and dma_req reads of FF90 and FFA0 → CPU acked first; DMA acked 2 cycles later; hram_a sequence 8'h90, 8'hA0.
- Read of 8'h7F and of 8'hFF → ack after 2 cycles, rdata 8'hFF; hram_ffxx/hram_rd never asserted.
- With HRAM_ARB_STARVE_EN, continuous cpu_req plus dma_req held → DMA wins every 4th slot. Without the macro, DMA is never acked while cpu_req stays high.
- n_reset pulled low during ACCESS of a write → strobes and busy go 0 asynchronously, no ack. After release: IDLE, and the next request completes in 2 cycles.
